// File: rtl/tile_sched_pkg.sv
// Shared types for the layer tile scheduler: FSM states, DMA kinds, flag bit positions.
package tile_sched_pkg;

    typedef enum logic [2:0] {
        IDLE, LD_W, LD_I, LD_B, PASS, WAIT_P, ST_O, DONE
    } state_t;

    typedef enum logic [1:0] {DMA_W, DMA_I, DMA_B, DMA_O} dma_kind_t;

    localparam int BIAS_BYTES = 4;
    localparam int FLG_FIRST  = 0;
    localparam int FLG_LAST   = 1;
    localparam int FLG_BIAS   = 3;

    function automatic logic is_dma(input state_t s);
        return (s == LD_W) || (s == LD_I) || (s == LD_B) || (s == ST_O);
    endfunction

endpackage

// File: rtl/tile_loop_ctr.sv
// k/r/d tile counters for both loop orders, with next-value lookahead, first/last flags
// and the weight-reuse decision for the tile that follows the current one.
module tile_loop_ctr
    import tile_sched_pkg::*;
#(
    parameter int IDX_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc_d,
    input  logic             inc_kr,
    input  logic             pass_issue,
    input  logic             loop_order,
    input  logic             reuse_en,
    input  logic [IDX_W-1:0] num_k,
    input  logic [IDX_W-1:0] num_r,
    input  logic [IDX_W-1:0] num_d,
    output logic [IDX_W-1:0] k,
    output logic [IDX_W-1:0] r,
    output logic [IDX_W-1:0] d,
    output logic [IDX_W-1:0] k_nx,
    output logic [IDX_W-1:0] r_nx,
    output logic [IDX_W-1:0] d_nx,
    output logic             d_first,
    output logic             d_last,
    output logic             kr_last,
    output logic             skip_w
);
    logic             seen;
    logic             k_end, r_end;
    logic [IDX_W-1:0] k_adv, r_adv;

    assign k_end   = (k == num_k - IDX_W'(1));
    assign r_end   = (r == num_r - IDX_W'(1));
    assign d_first = (d == '0);
    assign d_last  = (d == num_d - IDX_W'(1));
    assign kr_last = k_end && r_end;

    // Position of the following output tile, independent of whether we advance now.
    always_comb begin
        k_adv = k;
        r_adv = r;
        if (!loop_order) begin
            if (r_end) begin
                r_adv = '0;
                k_adv = k + IDX_W'(1);
            end else begin
                r_adv = r + IDX_W'(1);
            end
        end else begin
            if (k_end) begin
                k_adv = '0;
                r_adv = r + IDX_W'(1);
            end else begin
                k_adv = k + IDX_W'(1);
            end
        end
    end

    assign k_nx = clear ? '0 : (inc_kr ? k_adv : k);
    assign r_nx = clear ? '0 : (inc_kr ? r_adv : r);
    assign d_nx = (clear || inc_kr) ? '0 : (inc_d ? d + IDX_W'(1) : d);

    // A single D tile with the same k as the pass just finished leaves the weights resident.
    assign skip_w = reuse_en && (num_d == IDX_W'(1)) && seen && (k_adv == k);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k    <= '0;
            r    <= '0;
            d    <= '0;
            seen <= 1'b0;
        end else begin
            k <= k_nx;
            r <= r_nx;
            d <= d_nx;
            if (clear)           seen <= 1'b0;
            else if (pass_issue) seen <= 1'b1;
        end
    end

endmodule

// File: rtl/tile_scheduler_p.sv
// Walks the K/R/D tile nest of one layer, sequencing weight/ifmap/bias loads, PE passes and ofmap stores.
// DMA request is registered and valid from the first cycle of each DMA state; each step waits on its completion pulse.
module tile_scheduler_p
    import tile_sched_pkg::*;
#(
    parameter int IDX_W  = 7,
    parameter int DIM_W  = 10,
    parameter int ADDR_W = 32,
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uLD_en_i,
    input  logic [IDX_W-1:0]  tile_R_i,
    input  logic [IDX_W-1:0]  tile_D_i,
    input  logic [IDX_W-1:0]  tile_K_i,
    input  logic [IDX_W-1:0]  out_tile_R_i,
    input  logic [IDX_W-1:0]  num_tiles_R_i,
    input  logic [IDX_W-1:0]  num_tiles_D_i,
    input  logic [IDX_W-1:0]  num_tiles_K_i,
    input  logic [DIM_W-1:0]  in_C_i,
    input  logic [DIM_W-1:0]  in_D_i,
    input  logic [DIM_W-1:0]  out_C_i,
    input  logic [ADDR_W-1:0] base_ifmap_i,
    input  logic [ADDR_W-1:0] base_weight_i,
    input  logic [ADDR_W-1:0] base_bias_i,
    input  logic [ADDR_W-1:0] base_ofmap_i,
    input  logic [FLAG_W-1:0] flags_i,
    input  logic              loop_order_i,
    input  logic              reuse_en_i,
    output logic              dma_enable_o,
    output logic              dma_read_o,
    output logic [ADDR_W-1:0] dma_addr_o,
    output logic [ADDR_W-1:0] dma_len_o,
    input  logic              dma_interrupt_i,
    output logic              pass_info_vld_o,
    output logic [IDX_W-1:0]  pass_tile_R_o,
    output logic [IDX_W-1:0]  pass_tile_D_o,
    output logic [IDX_W-1:0]  pass_tile_K_o,
    output logic [IDX_W-1:0]  pass_out_tile_R_o,
    output logic [IDX_W-1:0]  pass_k_idx_o,
    output logic [IDX_W-1:0]  pass_r_idx_o,
    output logic [IDX_W-1:0]  pass_d_idx_o,
    output logic [FLAG_W-1:0] pass_flags_o,
    input  logic              pass_done_i,
    output logic              busy_o,
    output logic              layer_done_o
);
    state_t            state, nxt;
    dma_kind_t         kind;
    logic              clear, latch, inc_d, inc_kr;
    logic [IDX_W-1:0]  tile_r_q, tile_d_q, tile_k_q, otile_r_q, nr_q, nd_q, nk_q;
    logic [DIM_W-1:0]  in_c_q, out_c_q;
    logic [ADDR_W-1:0] base_i_q, base_w_q, base_b_q, base_o_q;
    logic [FLAG_W-1:0] flags_q, pflags;
    logic              order_q, reuse_q;
    logic [IDX_W-1:0]  k, r, d, k_nx, r_nx, d_nx;
    logic              d_first, d_last, kr_last, skip_w;
    logic [IDX_W-1:0]  tk_s, td_s;
    logic [ADDR_W-1:0] bw_s, len_i, len_w, len_b, len_o, req_addr, req_len;

    tile_loop_ctr #(.IDX_W(IDX_W)) u_ctr (
        .clk(clk), .rst_n(rst_n), .clear(clear), .inc_d(inc_d), .inc_kr(inc_kr),
        .pass_issue(state == PASS), .loop_order(order_q), .reuse_en(reuse_q),
        .num_k(nk_q), .num_r(nr_q), .num_d(nd_q),
        .k(k), .r(r), .d(d), .k_nx(k_nx), .r_nx(r_nx), .d_nx(d_nx),
        .d_first(d_first), .d_last(d_last), .kr_last(kr_last), .skip_w(skip_w)
    );

    always_comb begin
        nxt    = state;
        clear  = 1'b0;
        latch  = 1'b0;
        inc_d  = 1'b0;
        inc_kr = 1'b0;
        case (state)
            IDLE: begin
                clear = 1'b1;
                if (uLD_en_i) begin
                    latch = 1'b1;
                    nxt = (num_tiles_R_i == '0 || num_tiles_D_i == '0 || num_tiles_K_i == '0)
                          ? DONE : LD_W;
                end
            end
            LD_W: if (dma_interrupt_i) nxt = LD_I;
            LD_I: if (dma_interrupt_i) nxt = (d_first && flags_q[FLG_BIAS]) ? LD_B : PASS;
            LD_B: if (dma_interrupt_i) nxt = PASS;
            PASS: nxt = WAIT_P;
            WAIT_P: begin
                if (pass_done_i) begin
                    if (d_last) begin
                        nxt = ST_O;
                    end else begin
                        inc_d = 1'b1;
                        nxt   = LD_W;
                    end
                end
            end
            ST_O: begin
                if (dma_interrupt_i) begin
                    if (kr_last) begin
                        nxt = DONE;
                    end else begin
                        inc_kr = 1'b1;
                        nxt    = skip_w ? LD_I : LD_W;
                    end
                end
            end
            default: nxt = IDLE;
        endcase
    end

    // The descriptor is latched on the same edge that issues the first weight load, so that request reads the live inputs.
    assign tk_s = (state == IDLE) ? tile_K_i      : tile_k_q;
    assign td_s = (state == IDLE) ? tile_D_i      : tile_d_q;
    assign bw_s = (state == IDLE) ? base_weight_i : base_w_q;

    assign len_w = ADDR_W'(tk_s) * ADDR_W'(td_s);
    assign len_i = ADDR_W'(tile_r_q) * ADDR_W'(in_c_q) * ADDR_W'(tile_d_q);
    assign len_b = ADDR_W'(tile_k_q) * ADDR_W'(BIAS_BYTES);
    assign len_o = ADDR_W'(otile_r_q) * ADDR_W'(out_c_q) * ADDR_W'(tile_k_q);

    always_comb begin
        case (nxt)
            LD_I:    kind = DMA_I;
            LD_B:    kind = DMA_B;
            ST_O:    kind = DMA_O;
            default: kind = DMA_W;
        endcase
        case (kind)
            DMA_I: begin
                req_addr = base_i_q + (ADDR_W'(r_nx) * ADDR_W'(nd_q) + ADDR_W'(d_nx)) * len_i;
                req_len  = len_i;
            end
            DMA_B: begin
                req_addr = base_b_q + ADDR_W'(k_nx) * len_b;
                req_len  = len_b;
            end
            DMA_O: begin
                req_addr = base_o_q + (ADDR_W'(k_nx) * ADDR_W'(nr_q) + ADDR_W'(r_nx)) * len_o;
                req_len  = len_o;
            end
            default: begin
                req_addr = bw_s + (ADDR_W'(k_nx) * ADDR_W'(nd_q) + ADDR_W'(d_nx)) * len_w;
                req_len  = len_w;
            end
        endcase
    end

    always_comb begin
        pflags            = flags_q;
        pflags[FLG_FIRST] = d_first;
        pflags[FLG_LAST]  = d_last;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {tile_r_q, tile_d_q, tile_k_q, otile_r_q, nr_q, nd_q, nk_q} <= '0;
            {in_c_q, out_c_q, base_i_q, base_w_q, base_b_q, base_o_q}   <= '0;
            {flags_q, order_q, reuse_q}                                 <= '0;
        end else if (latch) begin
            tile_r_q  <= tile_R_i;
            tile_d_q  <= tile_D_i;
            tile_k_q  <= tile_K_i;
            otile_r_q <= out_tile_R_i;
            nr_q      <= num_tiles_R_i;
            nd_q      <= num_tiles_D_i;
            nk_q      <= num_tiles_K_i;
            in_c_q    <= in_C_i;
            out_c_q   <= out_C_i;
            base_i_q  <= base_ifmap_i;
            base_w_q  <= base_weight_i;
            base_b_q  <= base_bias_i;
            base_o_q  <= base_ofmap_i;
            flags_q   <= flags_i;
            order_q   <= loop_order_i;
            reuse_q   <= reuse_en_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            dma_enable_o <= 1'b0;
            dma_read_o   <= 1'b0;
            dma_addr_o   <= '0;
            dma_len_o    <= '0;
            {pass_tile_R_o, pass_tile_D_o, pass_tile_K_o, pass_out_tile_R_o} <= '0;
            {pass_k_idx_o, pass_r_idx_o, pass_d_idx_o, pass_flags_o}         <= '0;
        end else begin
            state        <= nxt;
            dma_enable_o <= is_dma(nxt);
            dma_read_o   <= is_dma(nxt) && (kind != DMA_O);
            dma_addr_o   <= is_dma(nxt) ? req_addr : '0;
            dma_len_o    <= is_dma(nxt) ? req_len  : '0;
            if (nxt == PASS) begin
                pass_tile_R_o     <= tile_r_q;
                pass_tile_D_o     <= tile_d_q;
                pass_tile_K_o     <= tile_k_q;
                pass_out_tile_R_o <= otile_r_q;
                pass_k_idx_o      <= k;
                pass_r_idx_o      <= r;
                pass_d_idx_o      <= d;
                pass_flags_o      <= pflags;
            end
        end
    end

    assign busy_o          = (state != IDLE);
    assign layer_done_o    = (state == DONE);
    assign pass_info_vld_o = (state == PASS);

endmodule
